// File: rtl/gray_counter_if.sv
// Gray counter bus: count enable in, Gray/binary count and wrap pulse out.
//   enable : count enable, sampled on the rising clock edge
//   cnt    : registered Gray-code count
//   bin    : registered binary equivalent of cnt
//   wrap   : one-cycle pulse on the step that returns the count to zero
// master drives enable and observes the count; slave is the counter itself.
interface gray_counter_if #(
   parameter int WIDTH = 4
);
   logic             enable;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] bin;
   logic             wrap;

   modport master (output enable, input cnt, input bin, input wrap);
   modport slave  (input enable, output cnt, output bin, output wrap);
endinterface

// File: rtl/gray_counter.sv
// Free-running, enable-gated WIDTH-bit Gray-code counter (WIDTH 2..32).
// The binary register is the single source of truth; the Gray code is
// registered alongside it from the same next-state value, so cnt and bin
// change on the same edge and cnt never glitches.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (0 clears every output at once)
//   bus   : gray_counter_if.slave (enable in; cnt, bin, wrap out)
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   gray_counter_if.slave     bus
);

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;

   always_comb begin
      bin_d  = bin_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (bus.enable) begin
         bin_d  = bin_q + 1'b1;
         // Gray code of the value being loaded, not of the current one,
         // keeps cnt and bin in lockstep.
         cnt_d  = bin_d ^ (bin_d >> 1);
         // All-ones is the last state before the modulo rollover.
         wrap_d = (bin_q == {WIDTH{1'b1}});
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q  <= '0;
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.bin  = bin_q;
   assign bus.cnt  = cnt_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter at WIDTH=4 and WIDTH=3 side by side.
// The driver pushes the expected outputs for every clock edge into a queue;
// a monitor pops one entry per edge and compares. The reference Gray table
// is built by the reflect-and-prefix construction, indexed by an integer count.
module tb_gray_counter;

   localparam int M4 = 16;
   localparam int M3 = 8;

   typedef struct {
      logic [31:0] c4, b4, pc4;
      logic [31:0] c3, b3, pc3;
      logic        w4, w3;
      logic        st4, st3;
   } exp_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   int   cyc;
   bit   done;
   exp_t q[$];
   int   tab4[$];
   int   tab3[$];
   int   n4, n3;

   gray_counter_if #(.WIDTH(4)) bus4();
   gray_counter_if #(.WIDTH(3)) bus3();

   gray_counter #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
   gray_counter #(.WIDTH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endfunction

   // Reflected binary code: mirror the list so far and set the next bit.
   function automatic void build(int w, output int t[$]);
      t = {0};
      for (int k = 0; k < w; k++)
         for (int i = t.size() - 1; i >= 0; i--)
            t.push_back(t[i] | (1 << k));
   endfunction

   task automatic step(bit r, bit e4, bit e3);
      exp_t x;
      @(negedge clk);
      reset       = r;
      bus4.enable = e4;
      bus3.enable = e3;
      x.pc4 = tab4[n4];
      x.pc3 = tab3[n3];
      if (!r) begin
         n4 = 0; n3 = 0;
         x.w4 = 0; x.w3 = 0; x.st4 = 0; x.st3 = 0;
      end else begin
         x.w4  = e4 && (n4 == M4 - 1);
         x.w3  = e3 && (n3 == M3 - 1);
         x.st4 = e4;
         x.st3 = e3;
         if (e4) n4 = (n4 + 1) % M4;
         if (e3) n3 = (n3 + 1) % M3;
      end
      x.c4 = tab4[n4]; x.b4 = n4;
      x.c3 = tab3[n3]; x.b3 = n3;
      q.push_back(x);
   endtask

   // Assert reset between edges and check the outputs clear without a clock.
   task automatic async_reset();
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_cnt4",  bus4.cnt,  0);
      chk("async_bin4",  bus4.bin,  0);
      chk("async_wrap4", bus4.wrap, 0);
      chk("async_cnt3",  bus3.cnt,  0);
      chk("async_bin3",  bus3.bin,  0);
      chk("async_wrap3", bus3.wrap, 0);
      n4 = 0;
      n3 = 0;
   endtask

   // Monitor: one expectation per clock edge, sampled just after the edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            x = q.pop_front();
            chk("cnt4",  bus4.cnt,  x.c4);
            chk("bin4",  bus4.bin,  x.b4);
            chk("wrap4", bus4.wrap, x.w4);
            chk("cnt3",  bus3.cnt,  x.c3);
            chk("bin3",  bus3.bin,  x.b3);
            chk("wrap3", bus3.wrap, x.w3);
            if (x.st4) chk("gray_step4", $countones(bus4.cnt ^ x.pc4[3:0]), 1);
            if (x.st3) chk("gray_step3", $countones(bus3.cnt ^ x.pc3[2:0]), 1);
            chk("consist4", bus4.cnt, bus4.bin ^ (bus4.bin >> 1));
            chk("consist3", bus3.cnt, bus3.bin ^ (bus3.bin >> 1));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      tests = 0; fails = 0; cyc = 0; done = 0;
      n4 = 0; n3 = 0;
      build(4, tab4);
      build(3, tab3);
      reset       = 1'b0;
      bus4.enable = 1'b1;
      bus3.enable = 1'b1;
      #1;
      chk("rst_cnt4",  bus4.cnt,  0);
      chk("rst_wrap4", bus4.wrap, 0);
      chk("rst_cnt3",  bus3.cnt,  0);

      // Held in reset with enable high: nothing moves.
      repeat (3) step(0, 1, 1);

      // Full WIDTH=4 sequence, wrap, and one step past it.
      repeat (17) step(1, 1, 1);

      // Enable gating at bin=4 / cnt=0110.
      async_reset();
      step(0, 1, 1);
      repeat (4) step(1, 1, 1);
      repeat (5) step(1, 0, 0);
      step(1, 1, 1);

      // Count on to bin=9 (cnt=1101), then reset mid-operation.
      repeat (4) step(1, 1, 1);
      async_reset();
      step(0, 1, 1);
      step(1, 1, 1);

      // Randomized enables, independent per counter.
      for (int i = 0; i < 1000; i++)
         step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      @(posedge clk);
      #3;
      chk("queue_drained", q.size(), 0);
      done = 1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
